// File: rtl/synth_param_loader_pkg.sv
// rtl/synth_param_loader_pkg.sv - shared byte map, FSM encoding, signal-type codes and parameter-set type
package synth_param_loader_pkg;

  localparam logic [3:0] ADDR_FC0   = 4'd0;
  localparam logic [3:0] ADDR_FC1   = 4'd1;
  localparam logic [3:0] ADDR_FC2   = 4'd2;
  localparam logic [3:0] ADDR_FC3   = 4'd3;
  localparam logic [3:0] ADDR_TIMP0 = 4'd4;
  localparam logic [3:0] ADDR_TIMP1 = 4'd5;
  localparam logic [3:0] ADDR_TPER0 = 4'd6;
  localparam logic [3:0] ADDR_TPER1 = 4'd7;
  localparam logic [3:0] ADDR_NUM   = 4'd8;
  localparam logic [3:0] ADDR_DEV0  = 4'd9;
  localparam logic [3:0] ADDR_DEV1  = 4'd10;
  localparam logic [3:0] ADDR_DEV2  = 4'd11;
  localparam logic [3:0] ADDR_TYPE  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_START = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SIG_LFM   = 2'd0,
    SIG_PSK   = 2'd1,
    SIG_NOISE = 2'd2,
    SIG_RSVD  = 2'd3
  } sig_type_e;

  typedef struct packed {
    sig_type_e    sig_type;
    logic [31:0]  f_carrier;
    logic [9:0]   t_impulse;
    logic [12:0]  t_period;
    logic [4:0]   num_of_imp;
    logic [21:0]  deviation;
  } param_set_t;

  function automatic logic params_valid(input param_set_t p);
    return (p.t_impulse != '0) && ({3'b000, p.t_impulse} < p.t_period) &&
           (p.num_of_imp != '0) && (p.sig_type != SIG_RSVD);
  endfunction

endpackage

// File: rtl/synth_param_loader_run_timer.sv
// rtl/synth_param_loader_run_timer.sv - run-length down-counter with load, abort and expiry
module run_timer #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         abort,
  output logic         expire
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Abort wins over expiry so a last-cycle abort is still reported as an abort.
  assign expire = en && !abort && (count_q == W'(1));

  always_comb begin
    count_d = count_q;
    if (abort) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/synth_param_loader.sv
// rtl/synth_param_loader.sv - shadow parameter registers, validation FSM and start/run sequencing
module synth_param_loader
  import synth_param_loader_pkg::*;
#(
  parameter int RUN_CNT_W = 18
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WR_EN,
  input  logic [3:0]  WR_ADDR,
  input  logic [7:0]  WR_DATA,
  input  logic        CMD_START,
  input  logic        CMD_ABORT,
  output logic        SIGN_START_GEN,
  output logic [1:0]  SIGNAL_TYPE,
  output logic [31:0] F_CARRIER,
  output logic [9:0]  T_IMPULSE,
  output logic [12:0] T_PERIOD,
  output logic [4:0]  NUM_OF_IMP,
  output logic [21:0] DEVIATION,
  output logic        BUSY,
  output logic        DONE,
  output logic        PARAM_ERR
);

  param_set_t shadow_q;
  param_set_t shadow_d;
  param_set_t active_q;
  state_e     state_q;
  logic       busy_q;
  logic       done_q;
  logic       sign_start_gen_q;
  logic       param_err_q;

  logic                 shadow_valid;
  logic [17:0]          run_len;
  logic                 timer_load;
  logic                 timer_en;
  logic                 timer_abort;
  logic                 timer_expire;

  // Shadow bytes are writable in every state; unused upper bits are dropped.
  always_comb begin
    shadow_d = shadow_q;
    if (WR_EN) begin
      case (WR_ADDR)
        ADDR_FC0:   shadow_d.f_carrier[7:0]   = WR_DATA;
        ADDR_FC1:   shadow_d.f_carrier[15:8]  = WR_DATA;
        ADDR_FC2:   shadow_d.f_carrier[23:16] = WR_DATA;
        ADDR_FC3:   shadow_d.f_carrier[31:24] = WR_DATA;
        ADDR_TIMP0: shadow_d.t_impulse[7:0]   = WR_DATA;
        ADDR_TIMP1: shadow_d.t_impulse[9:8]   = WR_DATA[1:0];
        ADDR_TPER0: shadow_d.t_period[7:0]    = WR_DATA;
        ADDR_TPER1: shadow_d.t_period[12:8]   = WR_DATA[4:0];
        ADDR_NUM:   shadow_d.num_of_imp       = WR_DATA[4:0];
        ADDR_DEV0:  shadow_d.deviation[7:0]   = WR_DATA;
        ADDR_DEV1:  shadow_d.deviation[15:8]  = WR_DATA;
        ADDR_DEV2:  shadow_d.deviation[21:16] = WR_DATA[5:0];
        ADDR_TYPE:  shadow_d.sig_type         = sig_type_e'(WR_DATA[1:0]);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow_valid = params_valid(shadow_q);
  // 13-bit period times 5-bit count fits exactly in 18 bits.
  assign run_len      = 18'(shadow_q.t_period) * 18'(shadow_q.num_of_imp);
  assign timer_load   = (state_q == ST_CHECK) && shadow_valid;
  assign timer_en     = (state_q == ST_RUN);
  assign timer_abort  = (state_q == ST_RUN) && CMD_ABORT;

  run_timer #(
    .W (RUN_CNT_W)
  ) u_run_timer (
    .clk      (CLK),
    .rst      (RESET),
    .load     (timer_load),
    .load_val (RUN_CNT_W'(run_len)),
    .en       (timer_en),
    .abort    (timer_abort),
    .expire   (timer_expire)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q          <= ST_IDLE;
      active_q         <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      sign_start_gen_q <= 1'b0;
      param_err_q      <= 1'b0;
    end else begin
      done_q           <= 1'b0;
      sign_start_gen_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (CMD_START) begin
            state_q <= ST_CHECK;
            busy_q  <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (shadow_valid) begin
            state_q          <= ST_START;
            active_q         <= shadow_q;
            sign_start_gen_q <= 1'b1;
            param_err_q      <= 1'b0;
          end else begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            param_err_q <= 1'b1;
          end
        end
        ST_START: begin
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (timer_abort || timer_expire) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign SIGN_START_GEN = sign_start_gen_q;
  assign SIGNAL_TYPE    = active_q.sig_type;
  assign F_CARRIER      = active_q.f_carrier;
  assign T_IMPULSE      = active_q.t_impulse;
  assign T_PERIOD       = active_q.t_period;
  assign NUM_OF_IMP     = active_q.num_of_imp;
  assign DEVIATION      = active_q.deviation;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign PARAM_ERR      = param_err_q;

endmodule

// File: tb/tb_synth_param_loader.sv
// tb/tb_synth_param_loader.sv - randomized self-checking bench for synth_param_loader
module tb_synth_param_loader;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        WR_EN = 1'b0;
  logic [3:0]  WR_ADDR = '0;
  logic [7:0]  WR_DATA = '0;
  logic        CMD_START = 1'b0;
  logic        CMD_ABORT = 1'b0;
  logic        SIGN_START_GEN;
  logic [1:0]  SIGNAL_TYPE;
  logic [31:0] F_CARRIER;
  logic [9:0]  T_IMPULSE;
  logic [12:0] T_PERIOD;
  logic [4:0]  NUM_OF_IMP;
  logic [21:0] DEVIATION;
  logic        BUSY;
  logic        DONE;
  logic        PARAM_ERR;

  int n_chk = 0;
  int n_err = 0;

  int unsigned mb [16];
  logic [83:0] act_model = '0;
  logic [83:0] dut_vec;

  assign dut_vec = {SIGNAL_TYPE, F_CARRIER, T_IMPULSE, T_PERIOD, NUM_OF_IMP, DEVIATION};

  synth_param_loader #(.RUN_CNT_W(18)) dut (
    .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .CMD_START(CMD_START), .CMD_ABORT(CMD_ABORT), .SIGN_START_GEN(SIGN_START_GEN),
    .SIGNAL_TYPE(SIGNAL_TYPE), .F_CARRIER(F_CARRIER), .T_IMPULSE(T_IMPULSE),
    .T_PERIOD(T_PERIOD), .NUM_OF_IMP(NUM_OF_IMP), .DEVIATION(DEVIATION),
    .BUSY(BUSY), .DONE(DONE), .PARAM_ERR(PARAM_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: fields recovered from the raw written bytes with plain arithmetic.
  function automatic int unsigned m_timp(); return (mb[5] % 4) * 256 + mb[4]; endfunction
  function automatic int unsigned m_tper(); return (mb[7] % 32) * 256 + mb[6]; endfunction
  function automatic int unsigned m_num();  return mb[8] % 32; endfunction
  function automatic int unsigned m_type(); return mb[12] % 4; endfunction

  function automatic logic [83:0] shadow_vec();
    int unsigned fc, dev;
    fc  = mb[3] * 16777216 + mb[2] * 65536 + mb[1] * 256 + mb[0];
    dev = (mb[11] % 64) * 65536 + mb[10] * 256 + mb[9];
    return {2'(m_type()), fc, 10'(m_timp()), 13'(m_tper()), 5'(m_num()), 22'(dev)};
  endfunction

  function automatic bit model_valid();
    return (m_timp() != 0) && (m_tper() > m_timp()) && (m_num() != 0) && (m_type() != 3);
  endfunction

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
    @(negedge CLK);
    WR_EN = 1'b0;
    if (a < 4'd13) mb[a] = d;
  endtask

  task automatic write_set(input int unsigned timp, input int unsigned tper, input int unsigned num,
                           input int unsigned typ, input logic [31:0] fc, input int unsigned dev);
    wr(4'd0, fc[7:0]); wr(4'd1, fc[15:8]); wr(4'd2, fc[23:16]); wr(4'd3, fc[31:24]);
    wr(4'd4, 8'(timp % 256)); wr(4'd5, 8'(timp / 256 + ($urandom % 64) * 4));
    wr(4'd6, 8'(tper % 256)); wr(4'd7, 8'(tper / 256 + ($urandom % 8) * 32));
    wr(4'd8, 8'(num + ($urandom % 8) * 32));
    wr(4'd9, 8'(dev % 256)); wr(4'd10, 8'((dev / 256) % 256));
    wr(4'd11, 8'((dev / 65536) % 64 + ($urandom % 4) * 64));
    wr(4'd12, 8'(typ + ($urandom % 64) * 4));
  endtask

  // Issues one CMD_START (optionally with a same-cycle write) and measures the run until BUSY drops.
  task automatic observe_run(input int abort_at, input int restart_at, input bit sw_en,
                             input logic [3:0] sw_addr, input logic [7:0] sw_data,
                             output int busy_cnt, output int pulse_cnt, output int pulse_at,
                             output int done_cnt, output bit timed_out);
    busy_cnt = 0; pulse_cnt = 0; pulse_at = 0; done_cnt = 0; timed_out = 1'b1;
    CMD_START = 1'b1;
    if (sw_en) begin
      WR_EN = 1'b1; WR_ADDR = sw_addr; WR_DATA = sw_data;
      if (sw_addr < 4'd13) mb[sw_addr] = sw_data;
    end
    @(negedge CLK);
    WR_EN = 1'b0;
    for (int k = 1; k <= 5000; k++) begin
      if (BUSY) busy_cnt++;
      if (DONE) done_cnt++;
      if (SIGN_START_GEN) begin pulse_cnt++; pulse_at = k; end
      if (!BUSY) begin timed_out = 1'b0; break; end
      CMD_START = (k == restart_at);
      CMD_ABORT = (k == abort_at);
      @(negedge CLK);
    end
    CMD_START = 1'b0;
    CMD_ABORT = 1'b0;
  endtask

  task automatic test_reset();
    foreach (mb[i]) mb[i] = 0;
    @(negedge CLK);
    n_chk++;
    if ({BUSY, DONE, PARAM_ERR, SIGN_START_GEN, dut_vec} !== '0) begin
      n_err++; $display("FAIL reset_held: got %h expected 0", {BUSY, DONE, PARAM_ERR, SIGN_START_GEN, dut_vec});
    end
    RESET = 1'b0;
    CMD_ABORT = 1'b1;
    @(negedge CLK);
    CMD_ABORT = 1'b0;
    @(negedge CLK);
    n_chk++;
    if ({BUSY, DONE, PARAM_ERR, SIGN_START_GEN, dut_vec} !== '0) begin
      n_err++; $display("FAIL idle_abort: got %h expected 0", {BUSY, DONE, PARAM_ERR, SIGN_START_GEN, dut_vec});
    end
  endtask

  task automatic test_basic_run();
    int b, p, pa, d; bit to;
    write_set(100, 1000, 3, 0, $urandom, $urandom % 4194304);
    observe_run(0, 0, 1'b0, 4'd0, 8'd0, b, p, pa, d, to);
    act_model = shadow_vec();
    n_chk++; if (to !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got %0d expected 0", to); end
    n_chk++; if (p !== 1 || pa !== 2) begin n_err++; $display("FAIL basic_pulse: got count %0d at %0d expected 1 at 2", p, pa); end
    n_chk++; if (b !== 3002) begin n_err++; $display("FAIL basic_busy: got %0d expected 3002", b); end
    n_chk++; if (d !== 1) begin n_err++; $display("FAIL basic_done: got %0d expected 1", d); end
    n_chk++; if (dut_vec !== act_model) begin n_err++; $display("FAIL basic_outputs: got %h expected %h", dut_vec, act_model); end
  endtask

  task automatic test_invalid_start();
    int b, p, pa, d; bit to;
    write_set(100, 50, 2, 1, $urandom, $urandom % 4194304);
    observe_run(0, 0, 1'b0, 4'd0, 8'd0, b, p, pa, d, to);
    n_chk++; if (p !== 0 || d !== 0) begin n_err++; $display("FAIL invalid_pulse: got pulses %0d done %0d expected 0 0", p, d); end
    n_chk++; if (b !== 1) begin n_err++; $display("FAIL invalid_busy: got %0d expected 1", b); end
    n_chk++; if (PARAM_ERR !== 1'b1) begin n_err++; $display("FAIL invalid_err: got %b expected 1", PARAM_ERR); end
    n_chk++; if (dut_vec !== act_model) begin n_err++; $display("FAIL invalid_outputs: got %h expected %h", dut_vec, act_model); end
    wr(4'd6, 8'd200);
    wr(4'd8, 8'd1);
    observe_run(0, 0, 1'b0, 4'd0, 8'd0, b, p, pa, d, to);
    act_model = shadow_vec();
    n_chk++; if (PARAM_ERR !== 1'b0) begin n_err++; $display("FAIL err_cleared: got %b expected 0", PARAM_ERR); end
    n_chk++; if (b !== 202 || p !== 1) begin n_err++; $display("FAIL revalid_run: got busy %0d pulses %0d expected 202 1", b, p); end
  endtask

  task automatic test_shadow_isolation();
    int b, p, pa, d; bit to;
    logic [83:0] exp;
    write_set(5, 20, 2, 1, 32'hCAFEF00D, 100);
    exp = shadow_vec();
    CMD_START = 1'b1;
    @(negedge CLK);
    CMD_START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    wr(4'd0, 8'h78); wr(4'd1, 8'h56); wr(4'd2, 8'h34); wr(4'd3, 8'h12);
    n_chk++; if (F_CARRIER !== 32'hCAFEF00D || BUSY !== 1'b1) begin
      n_err++; $display("FAIL shadow_midrun: got %h busy %b expected cafef00d busy 1", F_CARRIER, BUSY);
    end
    for (int i = 0; i < 100 && BUSY; i++) @(negedge CLK);
    n_chk++; if (F_CARRIER !== 32'hCAFEF00D || BUSY !== 1'b0) begin
      n_err++; $display("FAIL shadow_after_run: got %h busy %b expected cafef00d busy 0", F_CARRIER, BUSY);
    end
    act_model = exp;
    observe_run(0, 0, 1'b0, 4'd0, 8'd0, b, p, pa, d, to);
    act_model = shadow_vec();
    n_chk++; if (F_CARRIER !== 32'h12345678 || dut_vec !== act_model) begin
      n_err++; $display("FAIL shadow_next_start: got %h expected %h", dut_vec, act_model);
    end
  endtask

  task automatic test_abort();
    int b, p, pa, d; bit to;
    int quiet;
    write_set(3, 30, 4, 2, $urandom, $urandom % 4194304);
    observe_run(12, 5, 1'b0, 4'd0, 8'd0, b, p, pa, d, to);
    act_model = shadow_vec();
    n_chk++; if (b !== 12 || d !== 1 || p !== 1) begin
      n_err++; $display("FAIL abort_run: got busy %0d done %0d pulses %0d expected 12 1 1", b, d, p);
    end
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (BUSY || SIGN_START_GEN || DONE) quiet++;
    end
    n_chk++; if (quiet !== 0) begin n_err++; $display("FAIL abort_idle_after: got %0d active cycles expected 0", quiet); end
  endtask

  task automatic test_same_cycle_write();
    int b, p, pa, d; bit to;
    write_set(4, 10, 0, 1, $urandom, $urandom % 4194304);
    observe_run(0, 0, 1'b1, 4'd8, 8'hE3, b, p, pa, d, to);
    act_model = shadow_vec();
    n_chk++; if (p !== 1 || b !== 32 || PARAM_ERR !== 1'b0) begin
      n_err++; $display("FAIL same_cycle_write: got pulses %0d busy %0d err %b expected 1 32 0", p, b, PARAM_ERR);
    end
    n_chk++; if (dut_vec !== act_model) begin n_err++; $display("FAIL same_cycle_outputs: got %h expected %h", dut_vec, act_model); end
  endtask

  task automatic test_max_product();
    write_set(1, 8191, 31, 2, $urandom, $urandom % 4194304);
    CMD_START = 1'b1;
    @(negedge CLK);
    CMD_START = 1'b0;
    @(negedge CLK);
    n_chk++; if (SIGN_START_GEN !== 1'b1 || dut.u_run_timer.count_q !== 18'(8191 * 31)) begin
      n_err++; $display("FAIL max_load: got pulse %b timer %0d expected 1 253921", SIGN_START_GEN, dut.u_run_timer.count_q);
    end
    CMD_ABORT = 1'b1;
    @(negedge CLK);
    n_chk++; if (BUSY !== 1'b1 || DONE !== 1'b0 || dut.u_run_timer.count_q !== 18'd253921) begin
      n_err++; $display("FAIL start_abort_ignored: got busy %b done %b timer %0d expected 1 0 253921", BUSY, DONE, dut.u_run_timer.count_q);
    end
    @(negedge CLK);
    CMD_ABORT = 1'b0;
    act_model = shadow_vec();
    n_chk++; if (BUSY !== 1'b0 || DONE !== 1'b1 || dut_vec !== act_model) begin
      n_err++; $display("FAIL max_abort: got busy %b done %b expected 0 1", BUSY, DONE);
    end
  endtask

  task automatic test_reset_mid_run();
    int b, p, pa, d; bit to;
    int dones;
    write_set(7, 100, 2, 0, $urandom | 32'h1, $urandom % 4194304);
    CMD_START = 1'b1;
    @(negedge CLK);
    CMD_START = 1'b0;
    repeat (20) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    n_chk++; if ({BUSY, DONE, PARAM_ERR, SIGN_START_GEN, dut_vec} !== '0) begin
      n_err++; $display("FAIL reset_midrun: got %h expected 0", {BUSY, DONE, PARAM_ERR, SIGN_START_GEN, dut_vec});
    end
    foreach (mb[i]) mb[i] = 0;
    act_model = '0;
    dones = 0;
    repeat (2) begin @(negedge CLK); if (DONE) dones++; end
    RESET = 1'b0;
    repeat (3) begin @(negedge CLK); if (DONE) dones++; end
    n_chk++; if (dones !== 0) begin n_err++; $display("FAIL reset_no_done: got %0d expected 0", dones); end
    observe_run(0, 0, 1'b0, 4'd0, 8'd0, b, p, pa, d, to);
    n_chk++; if (PARAM_ERR !== 1'b1 || p !== 0 || b !== 1) begin
      n_err++; $display("FAIL reset_shadow_cleared: got err %b pulses %0d busy %0d expected 1 0 1", PARAM_ERR, p, b);
    end
  endtask

  task automatic test_random();
    int b, p, pa, d; bit to;
    bit exp_valid;
    int exp_busy;
    for (int it = 0; it < 12; it++) begin
      write_set($urandom_range(0, 40), $urandom_range(0, 60), $urandom_range(0, 4),
                $urandom_range(0, 3), $urandom, $urandom % 4194304);
      wr(4'(13 + $urandom % 3), 8'($urandom));
      exp_valid = model_valid();
      exp_busy  = exp_valid ? 2 + int'(m_tper() * m_num()) : 1;
      if (exp_valid) act_model = shadow_vec();
      observe_run(0, 0, 1'b0, 4'd0, 8'd0, b, p, pa, d, to);
      n_chk++; if (b !== exp_busy || to !== 1'b0) begin
        n_err++; $display("FAIL rand_busy[%0d]: got %0d expected %0d", it, b, exp_busy);
      end
      n_chk++; if (p !== int'(exp_valid) || d !== int'(exp_valid) || (exp_valid && pa !== 2)) begin
        n_err++; $display("FAIL rand_pulses[%0d]: got pulse %0d@%0d done %0d expected %0d", it, p, pa, d, exp_valid);
      end
      n_chk++; if (PARAM_ERR !== !exp_valid) begin
        n_err++; $display("FAIL rand_err[%0d]: got %b expected %b", it, PARAM_ERR, !exp_valid);
      end
      n_chk++; if (dut_vec !== act_model) begin
        n_err++; $display("FAIL rand_outputs[%0d]: got %h expected %h", it, dut_vec, act_model);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_invalid_start();
    test_shadow_isolation();
    test_abort();
    test_same_cycle_write();
    test_max_product();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/synth_param_loader.md
SYNTH_PARAM_LOADER -- requirements
Module: synth_param_loader

Interface
REQ-001 Parameter RUN_CNT_W, default 18, SHALL set the run-timer width; it must be at least 13+5.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 WR_EN  input  1  SHALL be the register write strobe, one byte per cycle.
REQ-005 WR_ADDR  input  4  SHALL be the shadow-register byte address.
REQ-006 WR_DATA  input  8  SHALL be the write data byte.
REQ-007 CMD_START  input  1  SHALL be the generation request, sampled per cycle.
REQ-008 CMD_ABORT  input  1  SHALL terminate an active run.
REQ-009 SIGN_START_GEN  output  1  SHALL be a one-cycle start pulse to the synthesizer.
REQ-010 SIGNAL_TYPE[1:0], F_CARRIER[31:0], T_IMPULSE[9:0], T_PERIOD[12:0], NUM_OF_IMP[4:0], DEVIATION[21:0]  outputs SHALL be the active parameter set.
REQ-011 BUSY  output  1  SHALL be high from acceptance of CMD_START until the run ends.
REQ-012 DONE  output  1  SHALL be a one-cycle pulse at the end of a run, whether completed or aborted.
REQ-013 PARAM_ERR  output  1  SHALL be a sticky flag for the last rejected start.

Function
REQ-014 Byte map, LSB first: 0-3 F_CARRIER; 4-5 T_IMPULSE; 6-7 T_PERIOD; 8 NUM_OF_IMP; 9-11 DEVIATION; 12 SIGNAL_TYPE.
REQ-015 Unused upper bits of each byte SHALL be discarded; writes to addresses 13-15 SHALL be ignored.
REQ-016 Writes SHALL update shadow registers only, in any state; active outputs SHALL change only on entry to START.
REQ-017 FSM states: IDLE, CHECK, START, RUN.
REQ-018 IDLE -> CHECK on CMD_START; CMD_START in any other state SHALL be ignored.
REQ-019 In CHECK, the shadow set is valid iff T_IMPULSE!=0, T_PERIOD>T_IMPULSE, NUM_OF_IMP!=0 and SIGNAL_TYPE!=3.
REQ-020 CHECK valid -> START, clearing PARAM_ERR; CHECK invalid -> IDLE, setting PARAM_ERR, with no pulse.
REQ-021 START SHALL copy shadow to active outputs, assert SIGN_START_GEN for exactly one cycle, load timer = T_PERIOD*NUM_OF_IMP (full-width product, no truncation), then go to RUN.
REQ-022 Latency: CMD_START sampled at cycle n SHALL give SIGN_START_GEN and updated outputs at cycle n+2.
REQ-023 RUN SHALL decrement the timer once per cycle; on timer==1 it SHALL go to IDLE with DONE high for that cycle.
REQ-024 CMD_ABORT in RUN SHALL go to IDLE next cycle with a DONE pulse; abort has priority over timer expiry in the same cycle.
REQ-025 CMD_ABORT outside RUN SHALL have no effect.
REQ-026 BUSY SHALL be high in CHECK, START and RUN.
REQ-027 A write and CMD_START in the same IDLE cycle: CHECK SHALL see the newly written byte.

Reset
REQ-028 RESET SHALL clear all shadow and active registers, timer, BUSY, DONE, PARAM_ERR and SIGN_START_GEN to 0, and force IDLE, asynchronously.
REQ-029 RESET mid-run SHALL abandon the run without a DONE pulse.

Structure
REQ-030 A shared package SHALL hold the byte-address constants, FSM state encoding and the SIGNAL_TYPE codes (0 LFM, 1 PSK, 2 NOISE, 3 reserved).
REQ-031 The down-counter with load, abort and expiry SHALL be a sub-module named run_timer.

Verification
REQ-032 Load T_IMP=100, T_PER=1000, NUM=3, TYPE=0, then CMD_START -> SIGN_START_GEN at n+2, BUSY for 3002 cycles, DONE exactly once.
REQ-033 T_PER=50, T_IMP=100 and CMD_START -> no pulse, PARAM_ERR=1, BUSY high for 1 cycle; a subsequent valid start clears PARAM_ERR.
REQ-034 Write F_CARRIER=0x12345678 during RUN -> output F_CARRIER unchanged until the next START.
REQ-035 CMD_ABORT 10 cycles into RUN -> IDLE next cycle, DONE pulse; a second CMD_START during RUN is ignored.
REQ-036 RESET asserted mid-RUN -> all outputs 0 immediately, no DONE pulse.
REQ-037 T_PER=8191, NUM=31 -> timer loads 253921 with no overflow.
